// File: rtl/sump_initiator_if.sv
// Signal bundle between the SUMP command initiator and its surroundings:
// test-harness control, the UART TX/RX byte interfaces and the sample stream.
// master: the initiator itself. slave: the harness/UART side.
interface sump_initiator_if;
    // harness control and status
    logic        START;
    logic [23:0] DIV;
    logic [7:0]  TRIG_MASK;
    logic [7:0]  TRIG_SENS;
    logic        BUSY;
    logic        DONE;
    logic [1:0]  ERR;

    // UART byte interfaces
    logic        TX_START;
    logic [7:0]  TX_DATA;
    logic        TX_BUSY;
    logic        RX_READY;
    logic [7:0]  RX_DATA;

    // captured sample stream
    logic        SAMPLE_VALID;
    logic [7:0]  SAMPLE_DATA;

    modport master (
        input  START, DIV, TRIG_MASK, TRIG_SENS, TX_BUSY, RX_READY, RX_DATA,
        output TX_START, TX_DATA, SAMPLE_VALID, SAMPLE_DATA, BUSY, DONE, ERR
    );

    modport slave (
        output START, DIV, TRIG_MASK, TRIG_SENS, TX_BUSY, RX_READY, RX_DATA,
        input  TX_START, TX_DATA, SAMPLE_VALID, SAMPLE_DATA, BUSY, DONE, ERR
    );
endinterface

// File: rtl/sump_initiator.sv
// Host-side SUMP/OLS command initiator used for self-test of the capture core.
// Sends reset / (optional) ID query / divider and trigger configuration / arm
// through a byte UART, then forwards the sample dump as a strobed byte stream.
//
// Build option: define SUMP_ID_CHECK_EN to include the ID query (0x02) and the
// check of the "1ALS" reply. Without it the sequence goes RST_TX -> CFG_TX and
// ERR can only report a receive timeout.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for START
// RST_TX    | sending five 0x00 reset bytes
// ID_TX     | sending 0x02 ID query (SUMP_ID_CHECK_EN only)
// ID_RX     | checking the four-byte ID reply (SUMP_ID_CHECK_EN only)
// CFG_TX    | sending divider, trigger mask and trigger value commands
// ARM_TX    | sending 0x01 arm
// SAMP_RX   | forwarding SAMPLE_COUNT received bytes as samples
// FINISH    | one-cycle DONE pulse
module sump_initiator #(
    parameter int SAMPLE_COUNT   = 8192,
    parameter int TIMEOUT_CYCLES = 4_800_000
) (
    input  logic              CAP_CLK,
    input  logic              RST,
    sump_initiator_if.master  bus
);

    localparam int SCNT_W = $clog2(SAMPLE_COUNT + 1);
    localparam int TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SAMPLE_COUNT - 1);
    // The timer is loaded with TIMEOUT_CYCLES-1 so that reaching zero and then
    // seeing one more idle edge lands exactly TIMEOUT_CYCLES after the reload.
    localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RST_TX  = 3'd1;
`ifdef SUMP_ID_CHECK_EN
    localparam logic [2:0] S_ID_TX   = 3'd2;
    localparam logic [2:0] S_ID_RX   = 3'd3;
`endif
    localparam logic [2:0] S_CFG_TX  = 3'd4;
    localparam logic [2:0] S_ARM_TX  = 3'd5;
    localparam logic [2:0] S_SAMP_RX = 3'd6;
    localparam logic [2:0] S_FINISH  = 3'd7;

    // byte-send handshake phases
    localparam logic [1:0] PH_READY   = 2'd0;
    localparam logic [1:0] PH_WAIT_HI = 2'd1;
    localparam logic [1:0] PH_WAIT_LO = 2'd2;

    localparam logic [1:0] ERR_NONE    = 2'd0;
`ifdef SUMP_ID_CHECK_EN
    localparam logic [1:0] ERR_ID      = 2'd1;
`endif
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    logic [2:0]        state;
    logic [1:0]        tx_phase;
    logic [3:0]        byte_idx;
    logic [SCNT_W-1:0] samp_cnt;
    logic [TMR_W-1:0]  timer;
    logic [23:0]       div_q;
    logic [7:0]        mask_q;
    logic [7:0]        sens_q;

    logic              tx_start_q;
    logic [7:0]        tx_data_q;
    logic              sample_valid_q;
    logic [7:0]        sample_data_q;
    logic              busy_q;
    logic              done_q;
    logic [1:0]        err_q;

    logic              sending;
    logic [7:0]        tx_byte;
    logic [3:0]        last_idx;
    logic [2:0]        tx_next;
    logic              rx_wait;
    logic              tmr_expired;

    assign bus.TX_START     = tx_start_q;
    assign bus.TX_DATA      = tx_data_q;
    assign bus.SAMPLE_VALID = sample_valid_q;
    assign bus.SAMPLE_DATA  = sample_data_q;
    assign bus.BUSY         = busy_q;
    assign bus.DONE         = done_q;
    assign bus.ERR          = err_q;

`ifdef SUMP_ID_CHECK_EN
    assign rx_wait = (state == S_ID_RX) || (state == S_SAMP_RX);
`else
    assign rx_wait = (state == S_SAMP_RX);
`endif
    assign tmr_expired = (timer == '0);

    // Byte to send, last byte index and follow-on state for each sending state
    always_comb begin
        sending  = 1'b0;
        tx_byte  = 8'h00;
        last_idx = 4'd0;
        tx_next  = S_IDLE;
        case (state)
            S_RST_TX: begin
                sending  = 1'b1;
                tx_byte  = 8'h00;
                last_idx = 4'd4;
`ifdef SUMP_ID_CHECK_EN
                tx_next  = S_ID_TX;
`else
                tx_next  = S_CFG_TX;
`endif
            end
`ifdef SUMP_ID_CHECK_EN
            S_ID_TX: begin
                sending  = 1'b1;
                tx_byte  = 8'h02;
                last_idx = 4'd0;
                tx_next  = S_ID_RX;
            end
`endif
            S_CFG_TX: begin
                sending  = 1'b1;
                last_idx = 4'd14;
                tx_next  = S_ARM_TX;
                // three 5-byte long commands, little-endian arguments
                case (byte_idx)
                    4'd0:    tx_byte = 8'h80;
                    4'd1:    tx_byte = div_q[7:0];
                    4'd2:    tx_byte = div_q[15:8];
                    4'd3:    tx_byte = div_q[23:16];
                    4'd5:    tx_byte = 8'hC0;
                    4'd6:    tx_byte = mask_q;
                    4'd10:   tx_byte = 8'hC1;
                    4'd11:   tx_byte = sens_q;
                    default: tx_byte = 8'h00;
                endcase
            end
            S_ARM_TX: begin
                sending  = 1'b1;
                tx_byte  = 8'h01;
                last_idx = 4'd0;
                tx_next  = S_SAMP_RX;
            end
            default: begin
                sending = 1'b0;
            end
        endcase
    end

`ifdef SUMP_ID_CHECK_EN
    logic [7:0] id_exp;

    // Expected ID reply byte for the current position ("1ALS")
    always_comb begin
        id_exp = 8'h31;
        case (byte_idx[1:0])
            2'd0:    id_exp = 8'h31;
            2'd1:    id_exp = 8'h41;
            2'd2:    id_exp = 8'h4C;
            default: id_exp = 8'h53;
        endcase
    end
`endif

    // Inter-byte receive timer: reloaded outside the receive states and on every byte
    always_ff @(posedge CAP_CLK) begin
        if (RST) begin
            timer <= '0;
        end else if (!rx_wait || bus.RX_READY) begin
            timer <= TMR_LOAD;
        end else if (!tmr_expired) begin
            timer <= timer - 1'b1;
        end
    end

    // Command sequencer, UART handshake and sample forwarding
    always_ff @(posedge CAP_CLK) begin
        if (RST) begin
            state          <= S_IDLE;
            tx_phase       <= PH_READY;
            byte_idx       <= '0;
            samp_cnt       <= '0;
            div_q          <= '0;
            mask_q         <= '0;
            sens_q         <= '0;
            tx_start_q     <= 1'b0;
            tx_data_q      <= 8'h00;
            sample_valid_q <= 1'b0;
            sample_data_q  <= 8'h00;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= ERR_NONE;
        end else begin
            tx_start_q     <= 1'b0;
            sample_valid_q <= 1'b0;
            done_q         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.START) begin
                        div_q    <= bus.DIV;
                        mask_q   <= bus.TRIG_MASK;
                        sens_q   <= bus.TRIG_SENS;
                        err_q    <= ERR_NONE;
                        busy_q   <= 1'b1;
                        byte_idx <= '0;
                        samp_cnt <= '0;
                        tx_phase <= PH_READY;
                        state    <= S_RST_TX;
                    end
                end
`ifdef SUMP_ID_CHECK_EN
                S_ID_RX: begin
                    if (bus.RX_READY) begin
                        if (bus.RX_DATA != id_exp) begin
                            err_q  <= ERR_ID;
                            busy_q <= 1'b0;
                            state  <= S_IDLE;
                        end else if (byte_idx == 4'd3) begin
                            byte_idx <= '0;
                            state    <= S_CFG_TX;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                        end
                    end else if (tmr_expired) begin
                        err_q  <= ERR_TIMEOUT;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
`endif
                S_SAMP_RX: begin
                    // a byte arriving on the terminal-count cycle is kept
                    if (bus.RX_READY) begin
                        sample_valid_q <= 1'b1;
                        sample_data_q  <= bus.RX_DATA;
                        samp_cnt       <= samp_cnt + 1'b1;
                        if (samp_cnt == SCNT_LAST) begin
                            state <= S_FINISH;
                        end
                    end else if (tmr_expired) begin
                        err_q  <= ERR_TIMEOUT;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                S_FINISH: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    if (sending) begin
                        case (tx_phase)
                            PH_READY: begin
                                if (!bus.TX_BUSY) begin
                                    tx_start_q <= 1'b1;
                                    tx_data_q  <= tx_byte;
                                    tx_phase   <= PH_WAIT_HI;
                                end
                            end
                            PH_WAIT_HI: begin
                                if (bus.TX_BUSY) begin
                                    tx_phase <= PH_WAIT_LO;
                                end
                            end
                            PH_WAIT_LO: begin
                                if (!bus.TX_BUSY) begin
                                    tx_phase <= PH_READY;
                                    if (byte_idx == last_idx) begin
                                        byte_idx <= '0;
                                        state    <= tx_next;
                                    end else begin
                                        byte_idx <= byte_idx + 4'd1;
                                    end
                                end
                            end
                            default: begin
                                tx_phase <= PH_READY;
                            end
                        endcase
                    end else begin
                        // unused encodings fall back to IDLE
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/sump_initiator.md
# sump_initiator

Host-side SUMP/OLS command initiator for on-chip self-test of the capture core. Drives the capture core's serial command protocol through a byte-level UART transmitter, then consumes its UART receiver output: reset, optional ID check, divider/trigger configuration, arm, and reception of the full sample dump. Sits between the 48 MHz UART TX/RX byte interfaces and a test harness or soft-core that wants captured bytes as a valid-strobed stream.

## Interface

- `SAMPLE_COUNT`, default 8192: bytes expected after ARM.
- `TIMEOUT_CYCLES`, default 4_800_000: maximum CAP_CLK cycles between received bytes (100 ms at 48 MHz).
- `CAP_CLK`  in  1  system clock, 48 MHz; the only clock.
- `RST`  in  1  reset, synchronous, active-high.
- `START`  in  1  one-cycle request; ignored while `BUSY`.
- `DIV`  in  24  divider for command 0x80; latched on accepted `START`.
- `TRIG_MASK`  in  8  value for command 0xC0; latched on `START`.
- `TRIG_SENS`  in  8  value for command 0xC1; latched on `START`.
- `TX_START`  out  1  one-cycle byte-send strobe to UART TX.
- `TX_DATA`  out  8  byte to send; stable from strobe until `TX_BUSY` falls.
- `TX_BUSY`  in  1  UART TX busy.
- `RX_READY`  in  1  one-cycle strobe from UART RX.
- `RX_DATA`  in  8  received byte, valid with `RX_READY`.
- `SAMPLE_VALID`  out  1  one-cycle strobe per sample byte.
- `SAMPLE_DATA`  out  8  sample byte, valid with `SAMPLE_VALID`.
- `BUSY`  out  1  high from accepted `START` until `DONE`/error.
- `DONE`  out  1  one-cycle pulse on successful completion.
- `ERR`  out  2  0 none, 1 ID mismatch, 2 RX timeout; sticky until next accepted `START`.

## Operation

- States: IDLE, RST_TX, ID_TX, ID_RX, CFG_TX, ARM_TX, SAMP_RX, FINISH.
- IDLE: `START`=1 → latch DIV/TRIG_MASK/TRIG_SENS, clear `ERR`, clear byte counter, `BUSY`=1, → RST_TX.
- RST_TX: send 0x00 five times → ID_TX.
- ID_TX: send 0x02 → ID_RX.
- ID_RX: compare 4 received bytes against 0x31 0x41 0x4C 0x53 in order; any mismatch → `ERR`=1, `BUSY`=0, → IDLE immediately. All match → CFG_TX.
- CFG_TX: send 15 bytes: 0x80, DIV[7:0], DIV[15:8], DIV[23:16], 0x00; 0xC0, TRIG_MASK, 0x00, 0x00, 0x00; 0xC1, TRIG_SENS, 0x00, 0x00, 0x00 → ARM_TX.
- ARM_TX: send 0x01 → SAMP_RX.
- SAMP_RX: each `RX_READY` → `SAMPLE_VALID`=1, `SAMPLE_DATA`=`RX_DATA` next cycle; after `SAMPLE_COUNT` bytes → FINISH.
- FINISH: `DONE`=1 one cycle, `BUSY`=0 → IDLE.
- Byte send handshake: in a sending state with `TX_BUSY`=0 and no send outstanding, pulse `TX_START` one cycle with `TX_DATA`; wait for `TX_BUSY`=1, then `TX_BUSY`=0; then advance byte index.
- `RX_READY` outside ID_RX/SAMP_RX: discarded (includes stale bytes during RST_TX).
- Timeout: counter cleared on entry to ID_RX/SAMP_RX and on each `RX_READY`; reaching `TIMEOUT_CYCLES` → `ERR`=2, `BUSY`=0, → IDLE. No timeout in TX states.
- Byte counter width: clog2(`SAMPLE_COUNT`+1); no wrap; terminal compare exact.

## Timing

- Reset values: `TX_START`=0, `TX_DATA`=0x00, `SAMPLE_VALID`=0, `SAMPLE_DATA`=0x00, `BUSY`=0, `DONE`=0, `ERR`=0, state IDLE, counters 0.
- `RST` mid-operation: returns to IDLE next edge; in-flight UART byte is not aborted, no further `TX_START`.
- `START`→first `TX_START`: 2 cycles if `TX_BUSY`=0.
- `RX_READY`→`SAMPLE_VALID`: 1 cycle, registered.
- Last sample `SAMPLE_VALID` and `DONE`: `DONE` one cycle after last `SAMPLE_VALID`; `BUSY` falls with `DONE`.
- `START` coincident with `DONE` or error exit: ignored.
- `RX_READY` on the same cycle as timeout terminal count: byte wins, counter clears.

## Configuration

- `SUMP_ID_CHECK_EN` defined: ID_TX/ID_RX performed as above; `ERR`=1 reachable.
- Undefined: ID_TX/ID_RX removed; RST_TX → CFG_TX directly; `ERR` never 1; total bytes sent = 21 instead of 22.

## Test plan

- ID pass: START, DIV=0x000001, responder returns "1ALS", 8192 bytes 0x00..0xFF ramp → TX sequence 00×5,02,80,01,00,00,00,C0,…,01; 8192 `SAMPLE_VALID` matching ramp; `DONE` once; `ERR`=0.
- ID fail: responder returns 0x31,0x41,0x4C,0x54 → `ERR`=1, `BUSY`=0 right after 4th byte, no 0x80 sent.
- Timeout: responder stops after 100 samples, TIMEOUT_CYCLES=1000 → `ERR`=2 exactly 1000 cycles after 100th `RX_READY`; `DONE` never.
- Config encoding: DIV=0x0A0B0C, TRIG_MASK=0x5A, TRIG_SENS=0xA5 → bytes 80,0C,0B,0A,00,C0,5A,00,00,00,C1,A5,00,00,00.
- Reset mid-capture: RST at sample 4000 → all outputs reset next cycle; new START runs full sequence with `ERR`=0.
- Busy handshake: hold `TX_BUSY`=1 for 5000 cycles per byte → exactly one `TX_START` per byte, `TX_DATA` stable throughout.
